// File: rtl/sparse_pkg.sv
// ============================================================================
// sparse_pkg : shared types for the sparse element unpacker        (rev 1.0)
// ============================================================================
`default_nettype none

package sparse_pkg;

  localparam logic [5:0] HDR_MAGIC  = 6'b101000;
  localparam int         ELEM_IDX_W = 16;
  localparam int         ELEM_VAL_W = 16;

  typedef enum logic [2:0] {
    S_HDR   = 3'd0,
    S_IDX_H = 3'd1,
    S_IDX_L = 3'd2,
    S_VAL_H = 3'd3,
    S_VAL_L = 3'd4
  } unpack_state_t;

  typedef struct packed {
    logic                  sel;
    logic                  last;
    logic [ELEM_IDX_W-1:0] idx;
    logic [ELEM_VAL_W-1:0] val;
  } sparse_elem_t;

  function automatic logic hdr_ok(input logic [7:0] b);
    return b[7:2] == HDR_MAGIC;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sparse_element_unpacker_sync_fifo.sv
// ============================================================================
// sync_fifo : single-clock FIFO, push/pop may coincide when full   (rev 1.0)
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == C_FULL);
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= wr_q + PW'(1);
      end
      if (do_pop) rd_q <= rd_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/sparse_element_unpacker.sv
// ============================================================================
// sparse_element_unpacker : UART byte packets -> buffered sparse elements (rev 1.0)
// ============================================================================
`default_nettype none

module sparse_element_unpacker
  import sparse_pkg::*;
#(
  parameter int IDX_W       = 16,
  parameter int VAL_W       = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             elem_valid,
  input  logic             elem_ready,
  output logic             elem_sel,
  output logic             elem_last,
  output logic [IDX_W-1:0] elem_idx,
  output logic [VAL_W-1:0] elem_val,
  output logic             frame_err,
  output logic             overflow
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  unpack_state_t state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          sel_q, last_q;
  logic [15:0]   idx_q;
  logic [7:0]    valh_q;
  logic          ferr_q, ovf_q;

  logic          timeout, bad_hdr, push_req, pop, fifo_full, fifo_empty;
  sparse_elem_t  new_elem, head;

  assign bad_hdr  = (state_q == S_HDR) && rx_valid && !hdr_ok(rx_data);
  assign push_req = (state_q == S_VAL_L) && rx_valid;
  // A byte arriving on the expiry cycle wins over the timeout.
  assign timeout  = (state_q != S_HDR) && !rx_valid && (tmo_q == TO_LAST);
  assign pop      = !fifo_empty && elem_ready;
  assign new_elem = '{sel: sel_q, last: last_q, idx: idx_q, val: {valh_q, rx_data}};

  always_comb begin
    state_d = state_q;
    if (rx_valid) begin
      case (state_q)
        S_HDR:   state_d = hdr_ok(rx_data) ? S_IDX_H : S_HDR;
        S_IDX_H: state_d = S_IDX_L;
        S_IDX_L: state_d = S_VAL_H;
        S_VAL_H: state_d = S_VAL_L;
        default: state_d = S_HDR;
      endcase
    end else if (timeout) begin
      state_d = S_HDR;
    end
    tmo_d = (rx_valid || state_q == S_HDR || timeout) ? '0 : tmo_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_HDR;
      tmo_q   <= '0;
      sel_q   <= 1'b0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      valh_q  <= '0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      ferr_q  <= bad_hdr || timeout;
      if (push_req && fifo_full && !pop) ovf_q <= 1'b1;
      if (rx_valid) begin
        case (state_q)
          S_HDR:   begin sel_q <= rx_data[0]; last_q <= rx_data[1]; end
          S_IDX_H: idx_q[15:8] <= rx_data;
          S_IDX_L: idx_q[7:0]  <= rx_data;
          S_VAL_H: valh_q      <= rx_data;
          default: ;
        endcase
      end
    end
  end

  sync_fifo #(
    .WIDTH ($bits(sparse_elem_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .din   (new_elem),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign elem_valid = !fifo_empty;
  assign elem_sel   = head.sel;
  assign elem_last  = head.last;
  assign elem_idx   = head.idx;
  assign elem_val   = head.val;
  assign frame_err  = ferr_q;
  assign overflow   = ovf_q;

endmodule

`default_nettype wire
